// File: rtl/virtual_ds2431_mem_write_scratchpad_if.sv
// Bus between the function dispatcher / 1-Wire IO engine and the
// Write Scratchpad command engine.
//
// Handshake: a start is the rising edge of cmdRunTrig. Each byte transfer
// is requested by a one-cycle transTrig pulse with nRxTx/sentDat held stable.
// It completes on the rising edge of ByteTransDone, with recvDat valid at
// that edge. The end of the command, for any reason, is one cmdDone pulse.
interface virtual_ds2431_mem_write_scratchpad_if;
    logic        cmdRunTrig;
    logic        busReset;
    logic [7:0]  recvDat;
    logic        ByteTransDone;
    logic        transTrig;
    logic        nRxTx;
    logic [7:0]  sentDat;
    logic        cmdDone;
    logic [7:0]  TA1;
    logic [7:0]  TA2;
    logic [7:0]  ES;
    logic [63:0] scratchpad;
    logic        addrErr;
    logic [2:0]  state;

    modport master (
        output cmdRunTrig, busReset, recvDat, ByteTransDone,
        input  transTrig, nRxTx, sentDat, cmdDone, TA1, TA2, ES,
               scratchpad, addrErr, state
    );

    modport slave (
        input  cmdRunTrig, busReset, recvDat, ByteTransDone,
        output transTrig, nRxTx, sentDat, cmdDone, TA1, TA2, ES,
               scratchpad, addrErr, state
    );
endinterface

// File: rtl/virtual_ds2431_mem_write_scratchpad.sv
// DS2431 Write Scratchpad (0x0F) command engine: receives TA1/TA2 and data
// bytes through the shared byte IO engine, fills the 8-byte scratchpad from
// the start offset up to byte 7, then returns the inverted CRC16.
module virtual_ds2431_mem_write_scratchpad #(
    parameter logic [7:0]  CMD_CODE = 8'h0F,
    parameter logic [15:0] ADDR_MAX = 16'h008F
) (
    input  logic clk,
    input  logic rst,
    virtual_ds2431_mem_write_scratchpad_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RX_TA1  = 3'd1,
        RX_TA2  = 3'd2,
        RX_DAT  = 3'd3,
        TX_CRC0 = 3'd4,
        TX_CRC1 = 3'd5,
        FIN     = 3'd6
    } state_t;

    state_t      state;
    logic        trig_q;
    logic        trig_edge;
    logic        done_q;
    logic        done_edge;
    logic [7:0]  dat_q;
    logic [15:0] crc;
    logic [15:0] crc_next;
    logic [2:0]  offset;
    logic        aa;
    logic        pf;
    logic [2:0]  e;
    logic        data_any;

    // Reflected 0xA001 CRC16, one byte folded LSB first.
    function automatic logic [15:0] crc16_fold(input logic [15:0] c_in, input logic [7:0] d);
        logic [15:0] c;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ d[i]) c = (c >> 1) ^ 16'hA001;
            else             c = c >> 1;
        end
        return c;
    endfunction

    // CRC including the byte delivered by the current done edge.
    always_comb crc_next = crc16_fold(crc, dat_q);

    assign bus.ES    = {aa, 1'b0, pf, 2'b00, e};
    assign bus.state = state;

    // Edge detectors, command FSM and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            trig_q         <= 1'b0;
            trig_edge      <= 1'b0;
            done_q         <= 1'b0;
            done_edge      <= 1'b0;
            dat_q          <= 8'h00;
            crc            <= 16'h0000;
            offset         <= 3'd0;
            aa             <= 1'b0;
            pf             <= 1'b0;
            e              <= 3'd0;
            data_any       <= 1'b0;
            bus.transTrig  <= 1'b0;
            bus.nRxTx      <= 1'b0;
            bus.sentDat    <= 8'h00;
            bus.cmdDone    <= 1'b0;
            bus.TA1        <= 8'h00;
            bus.TA2        <= 8'h00;
            bus.scratchpad <= 64'h0;
            bus.addrErr    <= 1'b0;
        end else begin
            trig_q        <= bus.cmdRunTrig;
            trig_edge     <= bus.cmdRunTrig & ~trig_q;
            done_q        <= bus.ByteTransDone;
            done_edge     <= bus.ByteTransDone & ~done_q;
            dat_q         <= bus.recvDat;
            bus.transTrig <= 1'b0;
            bus.cmdDone   <= 1'b0;

            if (bus.busReset && state != IDLE) begin
                // Abort wins over a simultaneous done edge; that byte is dropped.
                state <= FIN;
                if (state == RX_DAT || !data_any) pf <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (trig_edge) begin
                            crc           <= crc16_fold(16'h0000, CMD_CODE);
                            aa            <= 1'b0;
                            pf            <= 1'b0;
                            bus.addrErr   <= 1'b0;
                            data_any      <= 1'b0;
                            bus.transTrig <= 1'b1;
                            bus.nRxTx     <= 1'b0;
                            state         <= RX_TA1;
                        end
                    end
                    RX_TA1: begin
                        if (done_edge) begin
                            bus.TA1       <= dat_q;
                            crc           <= crc_next;
                            bus.transTrig <= 1'b1;
                            bus.nRxTx     <= 1'b0;
                            state         <= RX_TA2;
                        end
                    end
                    RX_TA2: begin
                        if (done_edge) begin
                            bus.TA2 <= dat_q;
                            crc     <= crc_next;
                            if ({dat_q, bus.TA1} > ADDR_MAX) begin
                                bus.addrErr <= 1'b1;
                                state       <= FIN;
                            end else begin
                                offset        <= bus.TA1[2:0];
                                bus.transTrig <= 1'b1;
                                bus.nRxTx     <= 1'b0;
                                state         <= RX_DAT;
                            end
                        end
                    end
                    RX_DAT: begin
                        if (done_edge) begin
                            bus.scratchpad[{offset, 3'b000} +: 8] <= dat_q;
                            crc           <= crc_next;
                            e             <= offset;
                            data_any      <= 1'b1;
                            bus.transTrig <= 1'b1;
                            if (offset == 3'd7) begin
                                // Row end: first CRC byte goes out with the freshly folded value.
                                bus.nRxTx   <= 1'b1;
                                bus.sentDat <= ~crc_next[7:0];
                                state       <= TX_CRC0;
                            end else begin
                                offset    <= offset + 3'd1;
                                bus.nRxTx <= 1'b0;
                            end
                        end
                    end
                    TX_CRC0: begin
                        if (done_edge) begin
                            bus.transTrig <= 1'b1;
                            bus.nRxTx     <= 1'b1;
                            bus.sentDat   <= ~crc[15:8];
                            state         <= TX_CRC1;
                        end
                    end
                    TX_CRC1: begin
                        if (done_edge) state <= FIN;
                    end
                    FIN: begin
                        bus.cmdDone <= 1'b1;
                        state       <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_virtual_ds2431_mem_write_scratchpad.sv
// Bench for the Write Scratchpad engine: an IO-engine responder, a
// command-level model of the expected transfers and final state, and one
// monitor comparing the DUT against that model on every transfer and done.
module tb_virtual_ds2431_mem_write_scratchpad;
    logic clk = 1'b0;
    logic rst = 1'b1;

    virtual_ds2431_mem_write_scratchpad_if bus ();

    virtual_ds2431_mem_write_scratchpad dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock.
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int ref_cyc      = 0;
    int trans_cnt    = 0;
    int done_cnt     = 0;

    logic [8:0] exp_q[$];   // expected transfers: {nRxTx, sentDat}
    logic [7:0] rx_q[$];    // bytes the IO engine hands back on receives
    logic       io_stalled = 1'b0;
    logic       io_release = 1'b0;

    // Model of the command's visible state.
    logic [7:0] m_sp[8];
    logic [7:0] m_ta1      = 8'h00;
    logic [7:0] m_ta2      = 8'h00;
    logic [2:0] m_e        = 3'd0;
    logic [7:0] m_es       = 8'h00;
    logic       m_addr_err = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] model_crc(input logic [7:0] msg[$]);
        logic [15:0] c;
        c = 16'h0000;
        foreach (msg[i]) begin
            c = c ^ {8'h00, msg[i]};
            repeat (8) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    function automatic logic [63:0] model_sp();
        return {m_sp[7], m_sp[6], m_sp[5], m_sp[4], m_sp[3], m_sp[2], m_sp[1], m_sp[0]};
    endfunction

    task automatic model_reset();
        foreach (m_sp[i]) m_sp[i] = 8'h00;
        m_ta1 = 8'h00; m_ta2 = 8'h00; m_e = 3'd0; m_es = 8'h00; m_addr_err = 1'b0;
        exp_q.delete();
    endtask

    // IO engine: each transTrig drops done, then raises it three cycles later.
    // A receive with no byte queued stays pending until released.
    initial begin
        bus.ByteTransDone = 1'b1;
        bus.recvDat       = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (!rst && bus.transTrig) begin
                logic rx;
                rx = !bus.nRxTx;
                @(negedge clk);
                bus.ByteTransDone = 1'b0;
                if (rx && rx_q.size() == 0) begin
                    io_stalled = 1'b1;
                    for (int k = 0; k < 300 && !io_release; k++) @(negedge clk);
                    io_stalled = 1'b0;
                    bus.ByteTransDone = 1'b1;
                end else begin
                    repeat (3) @(negedge clk);
                    if (rx) bus.recvDat = rx_q.pop_front();
                    bus.ByteTransDone = 1'b1;
                end
            end
        end
    end

    // Monitor: every transTrig and cmdDone is compared against the model.
    initial begin
        logic prev_trig, prev_done, prev_br;
        logic [8:0] e;
        prev_trig = 1'b0; prev_done = 1'b1; prev_br = 1'b0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (!rst) begin
                if ((bus.cmdRunTrig && !prev_trig) || (bus.ByteTransDone && !prev_done) ||
                    (bus.busReset && !prev_br))
                    ref_cyc = cyc;
                if (bus.transTrig) begin
                    trans_cnt++;
                    check("trans_latency", 64'(cyc - ref_cyc), 64'd1);
                    if (exp_q.size() == 0) begin
                        check("unexpected_trans", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("trans_dir", 64'(bus.nRxTx), 64'(e[8]));
                        if (e[8]) check("tx_byte", 64'(bus.sentDat), 64'(e[7:0]));
                    end
                end
                if (bus.cmdDone) begin
                    done_cnt++;
                    check("done_latency", 64'((cyc - ref_cyc) <= 2), 64'd1);
                    check("pending_xfers", 64'(exp_q.size()), 64'd0);
                    check("ta1", 64'(bus.TA1), 64'(m_ta1));
                    check("ta2", 64'(bus.TA2), 64'(m_ta2));
                    check("es", 64'(bus.ES), 64'(m_es));
                    check("scratchpad", bus.scratchpad, model_sp());
                    check("addr_err", 64'(bus.addrErr), 64'(m_addr_err));
                end
            end
            prev_trig = bus.cmdRunTrig;
            prev_done = bus.ByteTransDone;
            prev_br   = bus.busReset;
        end
    end

    // Runs one command. data holds the bytes that complete; abort_kind 1/2
    // leaves the next data receive pending and then hits busReset / rst.
    task automatic run_cmd(input logic [7:0] ta1, input logic [7:0] ta2, input logic [7:0] data[$],
                           input int abort_kind, input int hold, input bit retrig);
        logic [7:0]  msg[$];
        logic [15:0] c;
        logic        pf;
        int          off, base_done, base_trans;
        bit          rt_sent, ab_sent;
        pf = 1'b0;
        m_ta1 = ta1; m_ta2 = ta2;
        m_addr_err = ({ta2, ta1} > 16'h008F);
        rx_q.push_back(ta1);
        rx_q.push_back(ta2);
        exp_q.push_back(9'h000);
        exp_q.push_back(9'h000);
        if (!m_addr_err) begin
            off = int'(ta1[2:0]);
            foreach (data[i]) begin
                rx_q.push_back(data[i]);
                exp_q.push_back(9'h000);
                m_sp[off + i] = data[i];
                m_e = 3'(off + i);
            end
            if (abort_kind != 0) begin
                exp_q.push_back(9'h000);
                pf = 1'b1;
            end else begin
                msg = {8'h0F, ta1, ta2};
                foreach (data[i]) msg.push_back(data[i]);
                c = model_crc(msg);
                exp_q.push_back({1'b1, ~c[7:0]});
                exp_q.push_back({1'b1, ~c[15:8]});
            end
        end
        m_es = {1'b0, 1'b0, pf, 2'b00, m_e};

        base_done  = done_cnt;
        base_trans = trans_cnt;
        rt_sent = 1'b0;
        ab_sent = 1'b0;
        @(negedge clk);
        bus.cmdRunTrig = 1'b1;
        repeat (hold) @(negedge clk);
        bus.cmdRunTrig = 1'b0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (retrig && !rt_sent && (trans_cnt - base_trans) >= 4) begin
                bus.cmdRunTrig = 1'b1;
                rt_sent = 1'b1;
            end else begin
                bus.cmdRunTrig = 1'b0;
            end
            if (abort_kind == 1 && io_stalled && !ab_sent) begin
                bus.busReset = 1'b1;
                io_release = 1'b1;
                ab_sent = 1'b1;
            end else begin
                bus.busReset = 1'b0;
            end
            if (abort_kind == 2 && ab_sent) begin
                rst = 1'b0;
                break;
            end
            if (abort_kind == 2 && io_stalled) begin
                rst = 1'b1;
                io_release = 1'b1;
                ab_sent = 1'b1;
            end
            if (done_cnt != base_done) break;
        end

        if (abort_kind == 2) begin
            check("rst_applied", 64'(ab_sent), 64'd1);
            model_reset();
            rx_q.delete();
            @(posedge clk); #1;
            check("post_rst_scratchpad", bus.scratchpad, 64'h0);
            check("post_rst_ctrl", 64'({bus.transTrig, bus.nRxTx, bus.cmdDone, bus.addrErr,
                                        bus.sentDat, bus.TA1, bus.TA2, bus.ES}), 64'h0);
            check("post_rst_state", 64'(bus.state), 64'd0);
        end else begin
            check("done_seen", 64'(done_cnt != base_done), 64'd1);
        end
        repeat (6) @(negedge clk);
        if (abort_kind != 2) check("done_count", 64'(done_cnt - base_done), 64'd1);
        io_release = 1'b0;
        bus.cmdRunTrig = 1'b0;
        bus.busReset = 1'b0;
    endtask

    // Watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timed out");
    end

    // Directed tests.
    initial begin
        logic [7:0] dq[$];
        logic [7:0] pin[$];
        int t0;
        bus.cmdRunTrig = 1'b0;
        bus.busReset   = 1'b0;
        model_reset();

        repeat (3) @(negedge clk);
        check("rst_scratchpad", bus.scratchpad, 64'h0);
        check("rst_ctrl", 64'({bus.transTrig, bus.nRxTx, bus.cmdDone, bus.addrErr,
                               bus.sentDat, bus.TA1, bus.TA2, bus.ES}), 64'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        pin = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        check("model_crc_pin", 64'(model_crc(pin)), 64'hBB3D);

        // Busy-free busReset in IDLE does nothing.
        @(negedge clk); bus.busReset = 1'b1;
        @(negedge clk); bus.busReset = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_busreset_done", 64'(done_cnt), 64'd0);

        // T1: full row from offset 0.
        dq = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        t0 = trans_cnt;
        run_cmd(8'h00, 8'h00, dq, 0, 1, 1'b0);
        check("t1_scratchpad", bus.scratchpad, 64'h8877665544332211);
        check("t1_es", 64'(bus.ES), 64'h07);
        check("t1_trans", 64'(trans_cnt - t0), 64'd12);

        // T2: start offset 5.
        dq = {8'hA1, 8'hA2, 8'hA3};
        t0 = trans_cnt;
        run_cmd(8'h1D, 8'h00, dq, 0, 1, 1'b0);
        check("t2_scratchpad", bus.scratchpad, 64'hA3A2A1_5544332211);
        check("t2_es", 64'(bus.ES), 64'h07);
        check("t2_trans", 64'(trans_cnt - t0), 64'd7);

        // T3: address above ADDR_MAX.
        dq = {};
        t0 = trans_cnt;
        run_cmd(8'h90, 8'h00, dq, 0, 1, 1'b0);
        check("t3_addr_err", 64'(bus.addrErr), 64'd1);
        check("t3_trans", 64'(trans_cnt - t0), 64'd2);
        check("t3_scratchpad", bus.scratchpad, 64'hA3A2A1_5544332211);

        // T4: busReset with the third data receive pending.
        dq = {8'hB1, 8'hB2};
        t0 = trans_cnt;
        run_cmd(8'h08, 8'h00, dq, 1, 1, 1'b0);
        check("t4_es", 64'(bus.ES), 64'h21);
        check("t4_trans", 64'(trans_cnt - t0), 64'd5);
        check("t4_scratchpad", bus.scratchpad, 64'hA3A2A1_554433B2B1);
        check("t4_addr_err", 64'(bus.addrErr), 64'd0);

        // T5: rst in RX_DAT, then a clean T1.
        dq = {8'hC1, 8'hC2};
        run_cmd(8'h00, 8'h00, dq, 2, 1, 1'b0);
        dq = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        t0 = trans_cnt;
        run_cmd(8'h00, 8'h00, dq, 0, 1, 1'b0);
        check("t5_scratchpad", bus.scratchpad, 64'h8877665544332211);
        check("t5_es", 64'(bus.ES), 64'h07);
        check("t5_trans", 64'(trans_cnt - t0), 64'd12);

        // T6: start held two cycles, retrigger during RX_DAT.
        dq = {8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hD5, 8'hD6, 8'hD7};
        t0 = trans_cnt;
        run_cmd(8'h00, 8'h00, dq, 0, 2, 1'b1);
        check("t6_trans", 64'(trans_cnt - t0), 64'd12);
        check("t6_scratchpad", bus.scratchpad, 64'hD7D6D5D4D3D2D1D0);
        repeat (20) @(negedge clk);
        check("t6_no_restart", 64'(trans_cnt - t0), 64'd12);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
